bch_syndrome_seq: RTL and testbench

Parametrised, streaming syndrome generator for binary primitive BCH(N=2^M-1) decoders.
- Accepts a received codeword P bits per beat over a valid/ready handshake.
- Accumulates all 2T syndromes S1..S2T by parallel Horner evaluation.
- Presents the syndromes plus an error-free flag on a held output handshake to the downstream key-equation solver.
- Successor of the combinational 31-bit, 4-syndrome unit: generalised in field size, correction capability and beat width, with flow control.

---
 rtl/bch_pkg.sv | 46 ++++
 rtl/bch_syndrome_lane.sv | 48 ++++
 rtl/bch_syndrome_seq.sv | 119 +++++++++++
 tb/tb_bch_syndrome_seq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// Shared GF(2^m) arithmetic and FSM state type for the BCH syndrome datapath.
// Functions take the field width and polynomial as arguments so one package serves every M.
package bch_pkg;

    localparam int unsigned GF_MAX_M = 16;

    typedef logic [GF_MAX_M-1:0] gf_elem_t;
    typedef logic [GF_MAX_M:0]   gf_poly_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    // Shift-and-add multiply, MSB of b first, reducing by poly whenever bit m appears.
    function automatic gf_elem_t gf_mul(input gf_elem_t a, input gf_elem_t b,
                                        input int unsigned m, input gf_poly_t poly);
        gf_poly_t r;
        gf_poly_t top;
        gf_elem_t bsel;
        r   = '0;
        top = gf_poly_t'(1) << m;
        for (int unsigned i = 0; i < m; i++) begin
            r = r << 1;
            if ((r & top) != '0)
                r = r ^ poly;
            bsel = gf_elem_t'(1) << (m - 1 - i);
            if ((b & bsel) != '0)
                r = r ^ {1'b0, a};
        end
        return r[GF_MAX_M-1:0];
    endfunction

    function automatic gf_elem_t gf_pow(input int unsigned e, input int unsigned m,
                                        input gf_poly_t poly);
        gf_elem_t    r;
        int unsigned n;
        n = (1 << m) - 1;
        r = gf_elem_t'(1);
        for (int unsigned i = 0; i < e % n; i++)
            r = gf_mul(r, gf_elem_t'(2), m, poly);
        return r;
    endfunction

endpackage

// File: rtl/bch_syndrome_lane.sv
// One syndrome accumulator S_J: Horner step over a P-bit beat using elaboration-time
// constant multipliers alpha^(J*P) and alpha^(J*k).
module bch_syndrome_lane
    import bch_pkg::*;
#(
    parameter int unsigned M         = 5,
    parameter int unsigned P         = 1,
    parameter int unsigned J         = 1,
    parameter int unsigned PRIM_POLY = 'h25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         first,
    input  logic [P-1:0] data,
    output logic [M-1:0] syn,
    output logic [M-1:0] syn_nxt
);

    localparam gf_poly_t POLY  = gf_poly_t'(PRIM_POLY);
    localparam gf_elem_t MUL_C = gf_pow(J * P, M, POLY);

    function automatic logic [P*M-1:0] build_ktab();
        logic [P*M-1:0] t;
        t = '0;
        for (int unsigned k = 0; k < P; k++)
            t[k*M +: M] = M'(gf_pow(J * k, M, POLY));
        return t;
    endfunction

    localparam logic [P*M-1:0] KTAB = build_ktab();

    always_comb begin
        syn_nxt = first ? '0 : M'(gf_mul(gf_elem_t'(syn), MUL_C, M, POLY));
        for (int unsigned k = 0; k < P; k++) begin
            if (data[k])
                syn_nxt = syn_nxt ^ KTAB[k*M +: M];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            syn <= '0;
        else if (load)
            syn <= syn_nxt;
    end

endmodule

// File: rtl/bch_syndrome_seq.sv
// Streaming BCH syndrome generator: accepts a codeword MSB-first P bits per beat and
// presents S1..S2T plus an error-free flag on a held valid/ready output.
module bch_syndrome_seq
    import bch_pkg::*;
#(
    parameter int unsigned M         = 5,
    parameter int unsigned T         = 2,
    parameter int unsigned P         = 1,
    parameter int unsigned PRIM_POLY = 'h25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [P-1:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*T*M-1:0]  out_syn,
    output logic              out_err_free
);

    localparam int unsigned N     = (1 << M) - 1;
    localparam int unsigned NS    = 2 * T;
    localparam int unsigned BEATS = (N + P - 1) / P;
    localparam int unsigned PAD   = BEATS * P - N;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);
    // Beat 0 carries positions above N-1 in its top PAD bits; they are forced to zero.
    localparam logic [P-1:0]  MASK0    = {P{1'b1}} >> PAD;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          first;
    logic          beat_acc;
    logic          last_beat;
    logic          err_free_nxt;
    logic [P-1:0]  data_m;
    logic [M-1:0]  syn_q [1:NS];
    logic [M-1:0]  syn_n [1:NS];

    assign first     = (state == IDLE);
    assign beat_acc  = in_valid && in_ready && !flush;
    assign last_beat = (cnt == CNT_LAST);
    assign data_m    = in_data & (first ? MASK0 : {P{1'b1}});

    for (genvar j = 1; j <= NS; j++) begin : g_lane
        bch_syndrome_lane #(
            .M         (M),
            .P         (P),
            .J         (j),
            .PRIM_POLY (PRIM_POLY)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (beat_acc),
            .first   (first),
            .data    (data_m),
            .syn     (syn_q[j]),
            .syn_nxt (syn_n[j])
        );
        assign out_syn[j*M-1 -: M] = syn_q[j];
    end

    always_comb begin
        logic [M-1:0] any;
        any = '0;
        for (int unsigned j = 1; j <= NS; j++)
            any = any | syn_n[j];
        err_free_nxt = (any == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            out_valid    <= 1'b0;
            out_err_free <= 1'b0;
            in_ready     <= 1'b1;
        end else if (flush) begin
            state        <= IDLE;
            cnt          <= '0;
            out_valid    <= 1'b0;
            out_err_free <= 1'b0;
            in_ready     <= 1'b1;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (beat_acc) begin
                        if (last_beat) begin
                            state        <= HOLD;
                            cnt          <= '0;
                            out_valid    <= 1'b1;
                            out_err_free <= err_free_nxt;
                            in_ready     <= 1'b0;
                        end else begin
                            state <= ACC;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state        <= IDLE;
                        out_valid    <= 1'b0;
                        out_err_free <= 1'b0;
                        in_ready     <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bch_syndrome_seq.sv
// Directed and random checks of bch_syndrome_seq (M=5, T=2) with P=1 and P=8 instances.
module tb_bch_syndrome_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;

    logic        in_valid1 = 1'b0;
    logic [0:0]  in_data1 = '0;
    logic        in_ready1;
    logic        out_valid1;
    logic        out_ready1 = 1'b0;
    logic [19:0] out_syn1;
    logic        out_ef1;

    logic        in_valid8 = 1'b0;
    logic [7:0]  in_data8 = '0;
    logic        in_ready8;
    logic        out_valid8;
    logic        out_ready8 = 1'b0;
    logic [19:0] out_syn8;
    logic        out_ef8;

    int unsigned nchecks = 0;
    int unsigned nerrs   = 0;

    localparam logic [19:0] E_P1  = {5'b10000, 5'b01000, 5'b00100, 5'b00010};
    localparam logic [19:0] E_P5  = {5'b01100, 5'b11111, 5'b10001, 5'b00101};
    localparam logic [19:0] E_P15 = {5'b11100, 5'b10111, 5'b10101, 5'b00111};
    localparam logic [19:0] E_P0  = {5'b00001, 5'b00001, 5'b00001, 5'b00001};
    localparam logic [30:0] CW_P1  = 31'h2;
    localparam logic [30:0] CW_P5  = 31'h20;
    localparam logic [30:0] CW_P15 = 31'h22;
    localparam logic [30:0] CW_P0  = 31'h1;

    always #5 clk = ~clk;

    bch_syndrome_seq #(.M(5), .T(2), .P(1), .PRIM_POLY('h25)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_syn(out_syn1), .out_err_free(out_ef1)
    );

    bch_syndrome_seq #(.M(5), .T(2), .P(8), .PRIM_POLY('h25)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_syn(out_syn8), .out_err_free(out_ef8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: alpha*a with x^5 = x^2 + 1, and direct evaluation of r(alpha^j).
    function automatic logic [4:0] xt(input logic [4:0] a);
        return {a[3:0], 1'b0} ^ (a[4] ? 5'b00101 : 5'b00000);
    endfunction

    function automatic logic [4:0] apow(input int unsigned e);
        logic [4:0] t;
        t = 5'b00001;
        for (int unsigned i = 0; i < e % 31; i++)
            t = xt(t);
        return t;
    endfunction

    function automatic logic [4:0] mul5(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] r;
        r = '0;
        for (int i = 4; i >= 0; i--) begin
            r = xt(r);
            if (b[i])
                r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [19:0] syn_model(input logic [30:0] cw);
        logic [19:0] s;
        s = '0;
        for (int unsigned j = 1; j <= 4; j++)
            for (int unsigned i = 0; i < 31; i++)
                if (cw[i])
                    s[j*5-1 -: 5] = s[j*5-1 -: 5] ^ apow(i * j);
        return s;
    endfunction

    task automatic beat1(input logic d);
        int unsigned g;
        bit took;
        g = 0;
        took = 0;
        in_valid1 = 1'b1;
        in_data1  = d;
        while (!took && g < 100) begin
            @(negedge clk);
            took = in_ready1;
            @(posedge clk);
            #1;
            g++;
        end
        in_valid1 = 1'b0;
        if (!took)
            check("beat1_timeout", 0, 1);
    endtask

    task automatic beat8(input logic [7:0] d);
        int unsigned g;
        bit took;
        g = 0;
        took = 0;
        in_valid8 = 1'b1;
        in_data8  = d;
        while (!took && g < 100) begin
            @(negedge clk);
            took = in_ready8;
            @(posedge clk);
            #1;
            g++;
        end
        in_valid8 = 1'b0;
        if (!took)
            check("beat8_timeout", 0, 1);
    endtask

    task automatic send1(input logic [30:0] cw, input int start_b);
        for (int b = start_b; b < 31; b++)
            beat1(cw[30-b]);
    endtask

    task automatic send8(input logic [30:0] cw, input logic pad);
        logic [31:0] w;
        w = {pad, cw};
        for (int b = 0; b < 4; b++)
            beat8(w[(3-b)*8 +: 8]);
    endtask

    task automatic get1(output logic [19:0] s, output logic ef, output int unsigned lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid1)
            check("out1_timeout", 0, 1);
        s  = out_syn1;
        ef = out_ef1;
        @(posedge clk); #1 out_ready1 = 1'b1;
        @(posedge clk); #1 out_ready1 = 1'b0;
    endtask

    task automatic get8(output logic [19:0] s, output logic ef, output int unsigned lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid8)
            check("out8_timeout", 0, 1);
        s  = out_syn8;
        ef = out_ef8;
        @(posedge clk); #1 out_ready8 = 1'b1;
        @(posedge clk); #1 out_ready8 = 1'b0;
    endtask

    task automatic sq_assert(input logic [19:0] s);
        assert (s[9:5] == mul5(s[4:0], s[4:0])) else $error("S2 != S1^2 for %h", s);
        assert (s[19:15] == mul5(s[9:5], s[9:5])) else $error("S4 != S2^2 for %h", s);
    endtask

    task automatic run1(input string tag, input logic [30:0] cw, input logic [19:0] exp,
                        input logic exp_ef);
        logic [19:0] s;
        logic ef;
        int unsigned lat;
        send1(cw, 0);
        get1(s, ef, lat);
        check({tag, ":syn"}, {12'b0, s}, {12'b0, exp});
        check({tag, ":ef"}, {31'b0, ef}, {31'b0, exp_ef});
        check({tag, ":lat"}, lat, 0);
        sq_assert(s);
    endtask

    task automatic run8(input string tag, input logic [30:0] cw, input logic pad,
                        input logic [19:0] exp, input logic exp_ef);
        logic [19:0] s;
        logic ef;
        int unsigned lat;
        send8(cw, pad);
        get8(s, ef, lat);
        check({tag, ":syn"}, {12'b0, s}, {12'b0, exp});
        check({tag, ":ef"}, {31'b0, ef}, {31'b0, exp_ef});
        check({tag, ":lat"}, lat, 0);
        sq_assert(s);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ":rdy1"}, {31'b0, in_ready1}, 1);
        check({tag, ":ov1"}, {31'b0, out_valid1}, 0);
        check({tag, ":syn1"}, {12'b0, out_syn1}, 0);
        check({tag, ":ef1"}, {31'b0, out_ef1}, 0);
        check({tag, ":ov8"}, {31'b0, out_valid8}, 0);
        check({tag, ":syn8"}, {12'b0, out_syn8}, 0);
    endtask

    initial begin
        logic [30:0] cw;
        logic [19:0] e;

        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run1("zero1", '0, '0, 1'b1);
        run1("p1_1", CW_P1, E_P1, 1'b0);
        run1("p5_1", CW_P5, E_P5, 1'b0);
        run1("p15_1", CW_P15, E_P15, 1'b0);

        run8("zero8", '0, 1'b1, '0, 1'b1);
        run8("p1_8", CW_P1, 1'b1, E_P1, 1'b0);
        run8("p5_8", CW_P5, 1'b1, E_P5, 1'b0);
        run8("p15_8", CW_P15, 1'b0, E_P15, 1'b0);

        // Backpressure in HOLD with the next codeword's first beat already offered.
        send1(CW_P1, 0);
        in_valid1 = 1'b1;
        in_data1  = CW_P5[30];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold:rdy", {31'b0, in_ready1}, 0);
            check("hold:ov", {31'b0, out_valid1}, 1);
            check("hold:syn", {12'b0, out_syn1}, {12'b0, E_P1});
            @(posedge clk);
            #1;
        end
        out_ready1 = 1'b1;
        @(posedge clk);
        #1 out_ready1 = 1'b0;
        @(negedge clk);
        check("bubble:ov", {31'b0, out_valid1}, 0);
        check("bubble:rdy", {31'b0, in_ready1}, 1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        send1(CW_P5, 1);
        begin
            logic [19:0] s;
            logic ef;
            int unsigned lat;
            get1(s, ef, lat);
            check("after_hold:syn", {12'b0, s}, {12'b0, E_P5});
            check("after_hold:lat", lat, 0);
        end

        // Flush after 10 beats; the beat offered during flush is dropped.
        for (int i = 0; i < 10; i++)
            beat1(1'b1);
        flush     = 1'b1;
        in_valid1 = 1'b1;
        in_data1  = 1'b1;
        @(negedge clk);
        check("flush:rdy", {31'b0, in_ready1}, 1);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        in_valid1 = 1'b0;
        @(negedge clk);
        check("flush:ov", {31'b0, out_valid1}, 0);
        @(posedge clk);
        #1;
        run1("p0_flush", CW_P0, E_P0, 1'b0);

        // Asynchronous reset mid-ACC.
        for (int i = 0; i < 10; i++)
            beat1(1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_acc");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset during HOLD.
        send1(CW_P5, 0);
        @(negedge clk);
        check("pre_rst:ov", {31'b0, out_valid1}, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run1("p1_post_rst", CW_P1, E_P1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            cw = 31'($urandom());
            e  = syn_model(cw);
            run1("rand1", cw, e, (e == '0));
        end
        for (int i = 0; i < 50; i++) begin
            cw = 31'($urandom());
            e  = syn_model(cw);
            run8("rand8", cw, 1'($urandom()), e, (e == '0));
        end

        $display("CHECKS %0d ERRORS %0d", nchecks, nerrs);
        $finish;
    end

endmodule
